// File: rtl/register_sequencer.sv
// Sequences read/write strobes of a four-entry register bank to execute
// LOADI / MOV / ADD, one instruction per valid/ready handshake.
module register_sequencer #(
  parameter int DATA_WIDTH = 2,
  parameter int REG_SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [REG_SEL_W-1:0]  instr_rd,
  input  logic [REG_SEL_W-1:0]  instr_rs,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  input  logic [DATA_WIDTH-1:0] rd_bus,
  output logic                  write_enable_1,
  output logic                  write_enable_2,
  output logic                  write_enable_3,
  output logic                  write_enable_4,
  output logic                  read_enable_1,
  output logic                  read_enable_2,
  output logic                  read_enable_3,
  output logic                  read_enable_4,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  done,
  output logic                  carry,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, READ_S, READ_D, WRITE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_LOADI, OP_MOV, OP_ADD} op_t;

  typedef struct packed {
    op_t                  op;
    logic [REG_SEL_W-1:0] rd;
  } instr_t;

  state_t                state;
  instr_t                cur;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [3:0]            we_q, re_q;
  logic [DATA_WIDTH:0]   sum_rd, sum_ab;
  op_t                   in_op;

  function automatic logic [3:0] onehot(input logic [REG_SEL_W-1:0] sel);
    return 4'b0001 << sel;
  endfunction

  assign in_op  = op_t'(instr_op);
  // sum_rd forms the ADD result while opB is still on rd_bus; sum_ab feeds carry
  assign sum_rd = {1'b0, op_a} + {1'b0, rd_bus};
  assign sum_ab = {1'b0, op_a} + {1'b0, op_b};

  assign {write_enable_4, write_enable_3, write_enable_2, write_enable_1} = we_q;
  assign {read_enable_4,  read_enable_3,  read_enable_2,  read_enable_1}  = re_q;

  // Outputs are loaded alongside the state they belong to, so every strobe is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      carry       <= 1'b0;
      we_q        <= '0;
      re_q        <= '0;
      data_in     <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            cur.op      <= in_op;
            cur.rd      <= instr_rd;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            if (in_op == OP_NOP || in_op == OP_LOADI) begin
              state   <= WRITE;
              done    <= 1'b1;
              data_in <= (in_op == OP_LOADI) ? instr_imm : '0;
              we_q    <= (in_op == OP_LOADI) ? onehot(instr_rd) : 4'b0000;
            end else begin
              state <= READ_S;
              re_q  <= onehot(instr_rs);
            end
          end
        end
        READ_S: begin
          op_a <= rd_bus;
          if (cur.op == OP_ADD) begin
            state <= READ_D;
            re_q  <= onehot(cur.rd);
          end else begin
            state   <= WRITE;
            re_q    <= '0;
            we_q    <= onehot(cur.rd);
            data_in <= rd_bus;
            done    <= 1'b1;
          end
        end
        READ_D: begin
          op_b    <= rd_bus;
          state   <= WRITE;
          re_q    <= '0;
          we_q    <= onehot(cur.rd);
          data_in <= sum_rd[DATA_WIDTH-1:0];
          done    <= 1'b1;
        end
        WRITE: begin
          if (cur.op == OP_ADD) carry <= sum_ab[DATA_WIDTH];
          state       <= IDLE;
          we_q        <= '0;
          data_in     <= '0;
          done        <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_sequencer.sv
// Bench for register_sequencer: a behavioural register bank sits on the strobes,
// an array-based ISA model predicts every write, read order, latency and carry.
module tb_register_sequencer;
  localparam int DW = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [1:0]    instr_op = '0;
  logic [SW-1:0] instr_rd = '0, instr_rs = '0;
  logic [DW-1:0] instr_imm = '0;
  logic [DW-1:0] rd_bus;
  logic          we1, we2, we3, we4, re1, re2, re3, re4;
  logic [DW-1:0] data_in;
  logic          done, carry, busy;
  logic [3:0]    we, re;

  register_sequencer #(.DATA_WIDTH(DW), .REG_SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm),
    .rd_bus(rd_bus),
    .write_enable_1(we1), .write_enable_2(we2), .write_enable_3(we3), .write_enable_4(we4),
    .read_enable_1(re1), .read_enable_2(re2), .read_enable_3(re3), .read_enable_4(re4),
    .data_in(data_in), .done(done), .carry(carry), .busy(busy)
  );

  assign we = {we4, we3, we2, we1};
  assign re = {re4, re3, re2, re1};

  always #5 clk = ~clk;

  // Register bank driven only by the DUT strobes
  logic [DW-1:0] bank [4] = '{default: '0};
  always_comb begin
    rd_bus = '0;
    for (int i = 0; i < 4; i++) if (re[i]) rd_bus = bank[i];
  end
  always @(posedge clk) for (int i = 0; i < 4; i++) if (we[i]) bank[i] <= data_in;

  int n_chk = 0, n_fail = 0, done_cnt = 0;
  int mr [4] = '{default: 0};
  bit mcarry = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("read_onehot0", 32'($onehot0(re)), 1);
      check("write_onehot0", 32'($onehot0(we)), 1);
      check("read_write_exclusive", 32'((re != 0) && (we != 0)), 0);
      if (done === 1'b1) done_cnt++;
    end
  end

  // ISA model: returns the expected write and updates architectural state.
  task automatic model_step(input logic [1:0] op, rd, rs, imm,
                            output logic [1:0] e_data, output logic [3:0] e_we, output int e_lat);
    int s;
    e_data = '0; e_we = '0; e_lat = 1;
    case (op)
      2'd1: begin e_data = imm; e_we = oh(rd); end
      2'd2: begin e_data = 2'(mr[rs]); e_we = oh(rd); e_lat = 2; end
      2'd3: begin
        s = mr[rs] + mr[rd];
        e_data = 2'(s % 4); e_we = oh(rd); e_lat = 3; mcarry = (s >= 4);
      end
      default: ;
    endcase
    if (op != 2'd0) mr[rd] = int'(e_data);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 4; i++) check({tag, "_bank"}, 32'(bank[i]), 32'(mr[i]));
  endtask

  // Issue one instruction from a negedge with the DUT idle; returns at the first idle negedge.
  task automatic exec(input logic [1:0] op, rd, rs, imm,
                      output int lat, output logic [3:0] w_we, output logic [1:0] w_data);
    logic [3:0] reads[$];
    logic [3:0] exp_reads[$];
    logic [1:0] e_data;
    logic [3:0] e_we;
    int e_lat, tmo;
    if (op == 2'd2) exp_reads = '{oh(rs)};
    if (op == 2'd3) exp_reads = '{oh(rs), oh(rd)};
    model_step(op, rd, rs, imm, e_data, e_we, e_lat);
    tmo = 0;
    while (instr_ready !== 1'b1 && tmo < 20) begin @(negedge clk); tmo++; end
    check("ready_before_issue", 32'(instr_ready), 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_imm = imm;
    @(posedge clk); #1 instr_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (re != 0) reads.push_back(re);
    end while (done !== 1'b1 && lat < 8);
    w_we = we; w_data = data_in;
    check("latency", 32'(lat), 32'(e_lat));
    check("read_count", 32'(reads.size()), 32'(exp_reads.size()));
    for (int i = 0; i < exp_reads.size() && i < reads.size(); i++)
      check("read_select", 32'(reads[i]), 32'(exp_reads[i]));
    check("write_enable", 32'(we), 32'(e_we));
    check("data_in", 32'(data_in), 32'(e_data));
    @(negedge clk);
    check("ready_after", 32'(instr_ready), 1);
    check("busy_after", 32'(busy), 0);
    check("carry", 32'(carry), 32'(mcarry));
    check_bank("exec");
  endtask

  typedef struct {
    logic [1:0] op, rd, rs, imm;
    int         lat;
    logic [3:0] we;
    logic [1:0] data;
    logic       c;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, rd, rs, imm, input int lat,
                              input logic [3:0] w, input logic [1:0] d, input logic c);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.imm = imm; v.lat = lat; v.we = w; v.data = d; v.c = c;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [9];
    int lat, d0, acc, guard;
    logic [3:0] w_we;
    logic [1:0] w_data, b0, e_data;
    logic [3:0] e_we;
    int e_lat;
    logic [1:0] q_op [4], q_rd [4], q_rs [4], q_imm [4];

    vt[0] = mk(2'd1, 2'd2, 2'd0, 2'd3, 1, 4'b0100, 2'd3, 1'b0); // LOADI R3=3
    vt[1] = mk(2'd1, 2'd0, 2'd0, 2'd2, 1, 4'b0001, 2'd2, 1'b0); // LOADI R1=2
    vt[2] = mk(2'd2, 2'd3, 2'd0, 2'd0, 2, 4'b1000, 2'd2, 1'b0); // MOV R4<-R1
    vt[3] = mk(2'd1, 2'd1, 2'd0, 2'd3, 1, 4'b0010, 2'd3, 1'b0); // LOADI R2=3
    vt[4] = mk(2'd3, 2'd3, 2'd1, 2'd0, 3, 4'b1000, 2'd1, 1'b1); // ADD R4+=R2
    vt[5] = mk(2'd1, 2'd0, 2'd0, 2'd1, 1, 4'b0001, 2'd1, 1'b1); // LOADI R1=1, carry sticky
    vt[6] = mk(2'd3, 2'd0, 2'd0, 2'd0, 3, 4'b0001, 2'd2, 1'b0); // ADD R1+=R1
    vt[7] = mk(2'd0, 2'd2, 2'd1, 2'd3, 1, 4'b0000, 2'd0, 1'b0); // NOP
    vt[8] = mk(2'd2, 2'd2, 2'd2, 2'd0, 2, 4'b0100, 2'd3, 1'b0); // MOV R3<-R3

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_we", 32'(we), 0);
    check("rst_re", 32'(re), 0);
    check("rst_data_in", 32'(data_in), 0);
    check("rst_carry", 32'(carry), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      exec(vt[i].op, vt[i].rd, vt[i].rs, vt[i].imm, lat, w_we, w_data);
      check("vec_latency", 32'(lat), 32'(vt[i].lat));
      check("vec_we", 32'(w_we), 32'(vt[i].we));
      check("vec_data", 32'(w_data), 32'(vt[i].data));
      check("vec_carry", 32'(carry), 32'(vt[i].c));
    end

    // Abort an ADD in READ_D with a two-cycle reset; carry must be set beforehand
    exec(2'd1, 2'd1, 2'd0, 2'd3, lat, w_we, w_data);
    exec(2'd3, 2'd1, 2'd1, 2'd0, lat, w_we, w_data);
    check("pre_abort_carry", 32'(carry), 1);
    instr_valid = 1'b1; instr_op = 2'd3; instr_rd = 2'd0; instr_rs = 2'd1; instr_imm = 2'd0;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_read_d", 32'(re), 32'(oh(2'd0)));
    d0 = done_cnt; b0 = bank[0];
    reset = 1'b1;
    @(posedge clk); #1 check("abort_done_0", 32'(done), 0);
    @(posedge clk); #1 check("abort_done_1", 32'(done), 0);
    @(negedge clk);
    check("abort_we", 32'(we), 0);
    check("abort_re", 32'(re), 0);
    check("abort_ready", 32'(instr_ready), 1);
    check("abort_carry", 32'(carry), 0);
    check("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    mcarry = 1'b0;
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_no_write", 32'(bank[0]), 32'(b0));
    check_bank("abort");

    // Four queued instructions with instr_valid held high throughout
    for (int i = 0; i < 4; i++) begin
      q_op[i] = 2'($urandom_range(0, 3)); q_rd[i] = 2'($urandom_range(0, 3));
      q_rs[i] = 2'($urandom_range(0, 3)); q_imm[i] = 2'($urandom_range(0, 3));
    end
    q_op[1] = 2'd3; q_op[2] = 2'd3;
    d0 = done_cnt; acc = 0; guard = 0;
    instr_valid = 1'b1;
    instr_op = q_op[0]; instr_rd = q_rd[0]; instr_rs = q_rs[0]; instr_imm = q_imm[0];
    while (acc < 4 && guard < 100) begin
      if (instr_ready === 1'b1) begin
        model_step(q_op[acc], q_rd[acc], q_rs[acc], q_imm[acc], e_data, e_we, e_lat);
        @(posedge clk); #1;
        acc++;
        if (acc < 4) begin
          instr_op = q_op[acc]; instr_rd = q_rd[acc]; instr_rs = q_rs[acc]; instr_imm = q_imm[acc];
        end else instr_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    check("queue_accepts", 32'(acc), 4);
    guard = 0;
    while (busy !== 1'b0 && guard < 10) begin @(negedge clk); guard++; end
    @(negedge clk);
    check("queue_idle", 32'(busy), 0);
    check("queue_done_count", 32'(done_cnt - d0), 4);
    check("queue_carry", 32'(carry), 32'(mcarry));
    check_bank("queue");

    for (int i = 0; i < 40; i++)
      exec(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), lat, w_we, w_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
